hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/sat_counter.sv | 49 ++++
 rtl/hazard_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard control unit:
//   - REG_W        : width of an architectural register specifier (5)
//   - hzd_state_e  : hazard FSM states RUN / MEM_WAIT / TIMEOUT
//   - load_use_hit : load-use hazard detection helper
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hzd_state_e;

    // A load in ID/EX whose destination is read by the instruction in IF/ID.
    // Register 0 is hardwired to zero, so a load targeting it never hazards.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt
    );
        return mem_read & (ex_rt != {REG_W{1'b0}}) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. Counts cycles where inc=1 and sticks at all-ones.
// With EN=0 no storage is built and count is tied to zero.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   srst  in  synchronous clear
//   inc   in  count enable for this cycle
//   count out current count (WIDTH bits)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16,
    parameter bit EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    generate
        if (EN) begin : g_cnt
            logic [WIDTH-1:0] count_r;

            // Saturating count register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_r <= {WIDTH{1'b0}};
                end else if (srst) begin
                    count_r <= {WIDTH{1'b0}};
                end else if (inc && (count_r != {WIDTH{1'b1}})) begin
                    count_r <= count_r + WIDTH'(1);
                end else begin
                    count_r <= count_r;
                end
            end

            assign count = count_r;
        end else begin : g_nocnt
            // Inputs are intentionally dropped when counting is disabled.
            logic unused_inputs_s;
            assign unused_inputs_s = ^{clk, rst_n, srst, inc};
            assign count           = {WIDTH{1'b0}};
        end
    endgenerate

endmodule

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait freezes with a sticky timeout.
//
// Build option: HZD_PERF_COUNT_EN -- when defined, stallCount counts stalled
// cycles (saturating); otherwise stallCount is tied to 0 with no flops.
//
// Ports:
//   clock        in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   ifIdRs/Rt    in   source register fields of the IF/ID instruction
//   idExRt       in   load destination of the ID/EX instruction
//   idExMemRead  in   ID/EX instruction is a load
//   branchTaken  in   branch resolved taken this cycle
//   memReq       in   EX/MEM issues a data-memory access
//   memReady     in   data memory completes the access this cycle
//   control      out  1 = bubble (zero ID/EX control)
//   pcWrite      out  PC write enable
//   ifIdWrite    out  IF/ID write enable
//   ifIdFlush    out  clear IF/ID to NOP
//   pipeFreeze   out  hold every pipeline register
//   memTimeout   out  sticky memory-timeout error
//   stallCount   out  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_W-1:0]     ifIdRs,
    input  logic [REG_W-1:0]     ifIdRt,
    input  logic [REG_W-1:0]     idExRt,
    input  logic                 idExMemRead,
    input  logic                 branchTaken,
    input  logic                 memReq,
    input  logic                 memReady,
    output logic                 control,
    output logic                 pcWrite,
    output logic                 ifIdWrite,
    output logic                 ifIdFlush,
    output logic                 pipeFreeze,
    output logic                 memTimeout,
    output logic [CNT_WIDTH-1:0] stallCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

`ifdef HZD_PERF_COUNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    hzd_state_e        state_r;
    hzd_state_e        state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_r;
    logic              mem_stall_s;
    logic              load_use_s;
    logic              stall_inc_s;

    assign mem_stall_s = memReq & ~memReady;
    assign load_use_s  = load_use_hit(idExMemRead, idExRt, ifIdRs, ifIdRt);

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (memReady) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r == WAIT_LIMIT) begin
                    state_nxt_s = TIMEOUT;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            TIMEOUT: begin
                state_nxt_s = TIMEOUT;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Memory wait counter: 1 on entry to MEM_WAIT, counts while waiting,
    // cleared in RUN, frozen in TIMEOUT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        wait_cnt_r <= WAIT_W'(1);
                    end else begin
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt_r != WAIT_LIMIT) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    wait_cnt_r <= wait_cnt_r;
                end
            endcase
        end
    end

    // Sticky timeout flag, set on the transition into TIMEOUT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else if ((state_r == MEM_WAIT) && (state_nxt_s == TIMEOUT)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign memTimeout = timeout_r;

    // FSM outputs (Mealy): memory wait > branch flush > load-use bubble.
    // While reset is held the pipeline sees plain RUN behaviour.
    always_comb begin
        control    = 1'b0;
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        pipeFreeze = 1'b0;
        if (!reset) begin
            control    = 1'b0;
            pcWrite    = 1'b1;
            ifIdWrite  = 1'b1;
            ifIdFlush  = 1'b0;
            pipeFreeze = 1'b0;
        end else if ((state_r != RUN) || mem_stall_s) begin
            pipeFreeze = 1'b1;
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            control    = 1'b0;
            ifIdFlush  = 1'b0;
        end else if (branchTaken) begin
            // The flushed instruction cannot consume the load, so no bubble.
            ifIdFlush  = 1'b1;
        end else if (load_use_s) begin
            control    = 1'b1;
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
        end else begin
            control    = 1'b0;
            pcWrite    = 1'b1;
        end
    end

    assign stall_inc_s = pipeFreeze | control;

    sat_counter #(
        .WIDTH (CNT_WIDTH),
        .EN    (PERF_EN)
    ) u_stall_cnt (
        .clk   (clock),
        .rst_n (reset),
        .srst  (1'b0),
        .inc   (stall_inc_s),
        .count (stallCount)
    );

endmodule
